bti_timer: RTL and testbench

BTI_TIMER -- requirements
Module: bti_timer

---
 rtl/bti_timer_pkg.sv | 27 ++
 rtl/bti_timer_if.sv | 28 ++
 rtl/bti_timer_presc.sv | 31 +++
 rtl/bti_timer.sv | 161 ++++++++++++++++
 tb/tb_bti_timer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/bti_timer_pkg.sv
// bti_timer_pkg: register map, CTRL bit positions, bus command codes and FSM
// states shared by the BTI machine timer and its prescaler.
package bti_timer_pkg;

   // Word offsets within the decoded low address bits.
   localparam logic [7:0] OFF_MTIME_LO    = 8'h00;
   localparam logic [7:0] OFF_MTIME_HI    = 8'h04;
   localparam logic [7:0] OFF_MTIMECMP_LO = 8'h08;
   localparam logic [7:0] OFF_MTIMECMP_HI = 8'h0C;
   localparam logic [7:0] OFF_CTRL        = 8'h10;
   localparam logic [7:0] OFF_PRESCALE    = 8'h14;

   // CTRL register bit positions.
   localparam int unsigned CTRL_EN = 0;
   localparam int unsigned CTRL_IE = 1;

   // Request channel command encoding.
   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   // Request/response FSM: IDLE accepts a request, RSP presents its response.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RSP  = 1'b1
   } state_t;

endpackage

// File: rtl/bti_timer_if.sv
// BTI request and response channels. The request channel carries a command
// from master to slave; the response channel carries read data and an error
// flag back from the slave, each with its own valid/ready handshake.
interface bti_req_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();
   logic          vld;
   logic          rdy;
   logic          cmd;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;

   modport mst (output vld, cmd, addr, wdata, input rdy);
   modport slv (input vld, cmd, addr, wdata, output rdy);
endinterface

interface bti_rsp_if #(
   parameter int DW = 32
) ();
   logic          vld;
   logic          rdy;
   logic [DW-1:0] rdata;
   logic          err;

   modport mst (output vld, rdata, err, input rdy);
   modport slv (input vld, rdata, err, output rdy);
endinterface

// File: rtl/bti_timer_presc.sv
// bti_timer_presc: 16-bit prescaler producing a one-cycle tick every
// (prescale + 1) enabled cycles. The count freezes while disabled and
// restarts from zero whenever the prescale value is rewritten.
module bti_timer_presc (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        clr,
   input  logic [15:0] prescale,
   output logic        tick
);

   logic [15:0] cnt_q;

   // Tick when the running count has reached the programmed terminal value.
   assign tick = en & (cnt_q == prescale);

   // Prescaler count: clear on reprogram, wrap on tick, hold while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values and simulation order cannot change the result.
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tick ? 16'd0 : cnt_q + 16'd1;
      end
   end

endmodule

// File: rtl/bti_timer.sv
// bti_timer: memory-mapped 64-bit machine timer (MTIME/MTIMECMP) on a BTI
// request/response bus. One transaction is outstanding at a time; writes
// commit and read data is captured at the accept edge, and the response is
// presented on the following cycle until the master takes it.
module bti_timer
   import bti_timer_pkg::*;
#(
   parameter int BTI_AW   = 32,
   parameter int BTI_DW   = 32,
   parameter int TIMER_AW = 5
) (
   input  logic   clk,
   input  logic   rst_n,
   bti_req_if.slv bti_req_slv,
   bti_rsp_if.mst bti_rsp_mst,
   output logic   timer_irq
);

   state_t              state_q, state_d;
   logic                req_rdy, rsp_vld;
   logic                accept;

   logic [7:0]          off;
   logic                mapped;
   logic [BTI_DW-1:0]   rd_val;
   logic [BTI_DW-1:0]   rdata_q;
   logic                err_q;

   logic                wr_en;
   logic                wr_mtime_lo, wr_mtime_hi;
   logic                wr_cmp_lo, wr_cmp_hi;
   logic                wr_ctrl, wr_prescale;

   logic [63:0]         mtime_q;
   logic [63:0]         mtimecmp_q;
   logic                ctrl_en_q, ctrl_ie_q;
   logic [15:0]         prescale_q;
   logic                tick;
   logic                irq_q;

   // Address bits above the decoded window do not select anything.
   logic                unused_addr;
   assign unused_addr = ^bti_req_slv.addr[BTI_AW-1:TIMER_AW];

   assign off = 8'(bti_req_slv.addr[TIMER_AW-1:0]);

   // Address decode and read mux. Every map entry is word aligned, so an
   // offset with addr[1:0] != 0 never matches and lands in the error case.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      rd_val = '0;
      mapped = 1'b1;
      case (off)
         OFF_MTIME_LO:    rd_val = mtime_q[31:0];
         OFF_MTIME_HI:    rd_val = mtime_q[63:32];
         OFF_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
         OFF_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
         OFF_CTRL: begin
            rd_val[CTRL_EN] = ctrl_en_q;
            rd_val[CTRL_IE] = ctrl_ie_q;
         end
         OFF_PRESCALE:    rd_val[15:0] = prescale_q;
         default:         mapped = 1'b0;
      endcase
   end

   // Next state and handshake outputs of the request/response FSM.
   always_comb begin
      state_d = state_q;
      req_rdy = 1'b0;
      rsp_vld = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_rdy = 1'b1;
            if (bti_req_slv.vld) state_d = ST_RSP;
         end
         ST_RSP: begin
            rsp_vld = 1'b1;
            if (bti_rsp_mst.rdy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register; reset drops any response in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   assign accept = req_rdy & bti_req_slv.vld;

   assign wr_en       = accept & (bti_req_slv.cmd == CMD_WRITE) & mapped;
   assign wr_mtime_lo = wr_en & (off == OFF_MTIME_LO);
   assign wr_mtime_hi = wr_en & (off == OFF_MTIME_HI);
   assign wr_cmp_lo   = wr_en & (off == OFF_MTIMECMP_LO);
   assign wr_cmp_hi   = wr_en & (off == OFF_MTIMECMP_HI);
   assign wr_ctrl     = wr_en & (off == OFF_CTRL);
   assign wr_prescale = wr_en & (off == OFF_PRESCALE);

   // Response capture at the accept edge, held until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         rdata_q <= (bti_req_slv.cmd == CMD_READ) ? rd_val : '0;
         err_q   <= ~mapped;
      end
   end

   assign bti_req_slv.rdy   = req_rdy;
   assign bti_rsp_mst.vld   = rsp_vld;
   assign bti_rsp_mst.rdata = rdata_q;
   assign bti_rsp_mst.err   = err_q;

   bti_timer_presc u_presc (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (ctrl_en_q),
      .clr      (wr_prescale),
      .prescale (prescale_q),
      .tick     (tick)
   );

   // Timer registers. A bus write to either MTIME half wins over a
   // coincident tick, and that tick is dropped for the whole 64-bit count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         ctrl_en_q  <= 1'b0;
         ctrl_ie_q  <= 1'b0;
         prescale_q <= '0;
      end else begin
         if (wr_mtime_lo)      mtime_q[31:0]  <= bti_req_slv.wdata[31:0];
         else if (wr_mtime_hi) mtime_q[63:32] <= bti_req_slv.wdata[31:0];
         else if (tick)        mtime_q        <= mtime_q + 64'd1;

         if (wr_cmp_lo) mtimecmp_q[31:0]  <= bti_req_slv.wdata[31:0];
         if (wr_cmp_hi) mtimecmp_q[63:32] <= bti_req_slv.wdata[31:0];

         if (wr_ctrl) begin
            ctrl_en_q <= bti_req_slv.wdata[CTRL_EN];
            ctrl_ie_q <= bti_req_slv.wdata[CTRL_IE];
         end

         if (wr_prescale) prescale_q <= bti_req_slv.wdata[15:0];
      end
   end

   // Interrupt level registered from timer state only, one cycle behind it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_q <= 1'b0;
      else        irq_q <= ctrl_ie_q & (mtime_q >= mtimecmp_q);
   end

   assign timer_irq = irq_q;

endmodule

// File: tb/tb_bti_timer.sv
// tb_bti_timer: directed bench for bti_timer. Inputs are driven and outputs
// sampled on the falling clock edge; expected values are hand-derived.
module tb_bti_timer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic timer_irq;

   int checks = 0;
   int failures = 0;

   bti_req_if #(.AW(32), .DW(32)) req_if ();
   bti_rsp_if #(.DW(32))          rsp_if ();

   bti_timer #(
      .BTI_AW   (32),
      .BTI_DW   (32),
      .TIMER_AW (5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bti_req_slv (req_if),
      .bti_rsp_mst (rsp_if),
      .timer_irq   (timer_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request and return on the falling edge after it is accepted.
   task automatic issue(input logic cmd, input logic [31:0] addr, input logic [31:0] wdata);
      int budget = 20;
      req_if.vld   = 1'b1;
      req_if.cmd   = cmd;
      req_if.addr  = addr;
      req_if.wdata = wdata;
      while (req_if.rdy !== 1'b1 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("req_rdy_wait", 32'(budget > 0), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_if.vld = 1'b0;
   endtask

   // Take the pending response with rsp.rdy high.
   task automatic complete(output logic [31:0] rdata, output logic err);
      chk("rsp_vld", 32'(rsp_if.vld), 32'd1);
      rdata = rsp_if.rdata;
      err   = rsp_if.err;
      rsp_if.rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
      logic [31:0] d;
      logic        e;
      issue(1'b1, addr, data);
      complete(d, e);
      chk($sformatf("wr_err_%0h", addr), 32'(e), 32'(exp_err));
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic err);
      issue(1'b0, addr, 32'h0);
      complete(data, err);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err);
      logic [31:0] d;
      logic        e;
      rd(addr, d, e);
      chk({tag, "_rdata"}, d, exp_data);
      chk({tag, "_err"}, 32'(e), 32'(exp_err));
   endtask

   initial begin
      logic [31:0] d, d2;
      logic        e;
      int          n;

      req_if.vld   = 1'b0;
      req_if.cmd   = 1'b0;
      req_if.addr  = '0;
      req_if.wdata = '0;
      rsp_if.rdy   = 1'b1;

      // Reset state.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_rdy", 32'(req_if.rdy), 32'd1);
      chk("rst_rsp_vld", 32'(rsp_if.vld), 32'd0);
      chk("rst_rdata",   rsp_if.rdata,    32'd0);
      chk("rst_err",     32'(rsp_if.err), 32'd0);
      chk("rst_irq",     32'(timer_irq),  32'd0);
      rd_chk("rst_mtime_lo", 32'h00, 32'h0, 1'b0);
      rd_chk("rst_mtime_hi", 32'h04, 32'h0, 1'b0);
      rd_chk("rst_cmp_lo",   32'h08, 32'hFFFF_FFFF, 1'b0);
      rd_chk("rst_cmp_hi",   32'h0C, 32'hFFFF_FFFF, 1'b0);
      rd_chk("rst_ctrl",     32'h10, 32'h0, 1'b0);
      rd_chk("rst_presc",    32'h14, 32'h0, 1'b0);

      // PRESCALE=3: one tick every 4 enabled cycles. EN goes high at the
      // CTRL accept edge A; ticks land on A+4, A+8, ... The read 40 cycles
      // later is accepted at A+42 and sees 10 ticks.
      wr(32'h14, 32'd3, 1'b0);
      wr(32'h10, 32'h1, 1'b0);
      repeat (40) @(negedge clk);
      rd(32'h00, d, e);
      chk("presc3_mtime_lo", d, 32'd10);
      // Second read accepted 8 cycles after the first: exactly two ticks.
      repeat (6) @(negedge clk);
      rd(32'h00, d2, e);
      chk("presc3_rate", d2 - d, 32'd2);
      // Disable at A+52 (tick on that edge still counts) -> frozen at 13.
      wr(32'h10, 32'h0, 1'b0);
      rd_chk("frozen_a", 32'h00, 32'd13, 1'b0);
      repeat (10) @(negedge clk);
      rd_chk("frozen_b", 32'h00, 32'd13, 1'b0);

      // Carry: PRESCALE=1 and EN on for exactly two edges gives one tick.
      wr(32'h14, 32'd1, 1'b0);
      wr(32'h04, 32'h0, 1'b0);
      wr(32'h00, 32'hFFFF_FFFF, 1'b0);
      wr(32'h10, 32'h1, 1'b0);
      wr(32'h10, 32'h0, 1'b0);
      rd_chk("carry_hi", 32'h04, 32'h1, 1'b0);
      rd_chk("carry_lo", 32'h00, 32'h0, 1'b0);

      // Write priority: PRESCALE=0, EN at P, MTIME_LO=5 at P+2 (tick lost),
      // EN off at P+4: ticks at P+1, P+3, P+4 -> LO=7, HI unchanged.
      wr(32'h14, 32'd0, 1'b0);
      wr(32'h10, 32'h1, 1'b0);
      wr(32'h00, 32'd5, 1'b0);
      wr(32'h10, 32'h0, 1'b0);
      rd_chk("prio_lo", 32'h00, 32'd7, 1'b0);
      rd_chk("prio_hi", 32'h04, 32'h1, 1'b0);

      // Interrupt: MTIME reaches 0x20 at C+32, irq rises at C+33.
      wr(32'h04, 32'h0, 1'b0);
      wr(32'h00, 32'h0, 1'b0);
      wr(32'h0C, 32'h0, 1'b0);
      wr(32'h08, 32'h20, 1'b0);
      chk("irq_low_ie0", 32'(timer_irq), 32'd0);
      wr(32'h10, 32'h3, 1'b0);
      n = 1;
      while (timer_irq !== 1'b1 && n < 80) begin
         @(negedge clk);
         n++;
      end
      chk("irq_rise_cycle", n, 32'd33);
      issue(1'b1, 32'h08, 32'h100);
      chk("irq_hold_at_accept", 32'(timer_irq), 32'd1);
      complete(d, e);
      chk("irq_cmp_wr_err", 32'(e), 32'd0);
      chk("irq_clear", 32'(timer_irq), 32'd0);

      // Back-pressure: response held 5 cycles with rsp.rdy low.
      rsp_if.rdy = 1'b0;
      issue(1'b0, 32'h08, 32'h0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_rsp_vld", 32'(rsp_if.vld), 32'd1);
         chk("stall_rdata",   rsp_if.rdata,    32'h100);
         chk("stall_req_rdy", 32'(req_if.rdy), 32'd0);
         @(negedge clk);
      end
      rsp_if.rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_hs_req_rdy", 32'(req_if.rdy), 32'd1);
      chk("post_hs_rsp_vld", 32'(rsp_if.vld), 32'd0);

      // Unmapped, unaligned and reserved-bit accesses.
      rd_chk("unmapped_rd", 32'h18, 32'h0, 1'b1);
      wr(32'h18, 32'hFFFF_FFFF, 1'b1);
      rd_chk("unaligned_rd", 32'h0A, 32'h0, 1'b1);
      wr(32'h0A, 32'h0, 1'b1);
      rd_chk("after_bad_cmp_lo", 32'h08, 32'h100, 1'b0);
      rd_chk("after_bad_cmp_hi", 32'h0C, 32'h0, 1'b0);
      rd_chk("after_bad_ctrl",   32'h10, 32'h3, 1'b0);
      rd_chk("after_bad_presc",  32'h14, 32'h0, 1'b0);
      rd_chk("high_addr_ignored", 32'h1000_0008, 32'h100, 1'b0);
      wr(32'h10, 32'hFFFF_FFFF, 1'b0);
      rd_chk("ctrl_reserved", 32'h10, 32'h3, 1'b0);
      wr(32'h14, 32'hFFFF_0000, 1'b0);
      rd_chk("presc_reserved", 32'h14, 32'h0, 1'b0);

      // Reset while a response is pending.
      wr(32'h08, 32'h0, 1'b0);
      @(negedge clk);
      chk("pre_rst_irq", 32'(timer_irq), 32'd1);
      rsp_if.rdy = 1'b0;
      issue(1'b0, 32'h00, 32'h0);
      chk("pre_rst_rsp_vld", 32'(rsp_if.vld), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_rsp_vld", 32'(rsp_if.vld), 32'd0);
      chk("mid_rst_req_rdy", 32'(req_if.rdy), 32'd1);
      chk("mid_rst_irq",     32'(timer_irq),  32'd0);
      chk("mid_rst_rdata",   rsp_if.rdata,    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_if.rdy = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_no_rsp", 32'(rsp_if.vld), 32'd0);
      end
      rd_chk("post_rst_cmp_lo",   32'h08, 32'hFFFF_FFFF, 1'b0);
      rd_chk("post_rst_cmp_hi",   32'h0C, 32'hFFFF_FFFF, 1'b0);
      rd_chk("post_rst_ctrl",     32'h10, 32'h0, 1'b0);
      rd_chk("post_rst_mtime_lo", 32'h00, 32'h0, 1'b0);
      chk("post_rst_irq", 32'(timer_irq), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
